// File: rtl/viterbi_pkg.sv
// Shared Viterbi codec definitions: default code parameters, encoder FSM
// states and the symbol-pair type used by the encoder and the BMC/ACS blocks.
package viterbi_pkg;

    localparam int         K_DEF      = 7;
    localparam logic [6:0] G0_DEF     = 7'o171;
    localparam logic [6:0] G1_DEF     = 7'o133;
    localparam int         NUM_STATES = 64;

    typedef enum logic {DATA, TAIL} enc_state_t;

    typedef logic [1:0] pair_t;

endpackage

// File: rtl/conv_enc_parity.sv
// Combinational generator taps: window bit K-1 is the current input, bit 0 the
// oldest. Output is {G1 parity, G0 parity}.
module conv_enc_parity
    import viterbi_pkg::*;
#(
    parameter int         K  = K_DEF,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic [K-1:0] window,
    output logic [1:0]   pair
);

    pair_t pair_p0;

    assign pair_p0 = {^(window & G1), ^(window & G0)};
    assign pair    = pair_p0;

endmodule

// File: rtl/conv_encoder_k7.sv
// Rate-1/2 feed-forward convolutional encoder with K-1 zero tail bits per frame.
// Define CONV_ENC_STATS_EN to add the frame_cnt / pair_cnt statistics outputs.
module conv_encoder_k7
    import viterbi_pkg::*;
#(
    parameter int           K  = K_DEF,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_bit,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_pair,
    output logic        out_last
`ifdef CONV_ENC_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [31:0] pair_cnt
`endif
);

    localparam int            TW        = $clog2(K);
    localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

    enc_state_t    state, state_nxt;
    logic [K-2:0]  sr;
    logic [TW-1:0] tail_cnt;
    logic          adv;
    logic          emit;
    logic          cur_bit;
    logic          last_pair;
    logic [K-1:0]  window;
    pair_t         pair_nxt;

    assign adv    = !out_valid || out_ready;
    assign window = {cur_bit, sr};

    conv_enc_parity #(.K(K), .G0(G0), .G1(G1)) u_parity (
        .window (window),
        .pair   (pair_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DATA;
        else     state <= state_nxt;
    end

    // in_ready is masked by rst so nothing looks acceptable while the encoder is held.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cur_bit   = 1'b0;
        emit      = 1'b0;
        last_pair = 1'b0;
        case (state)
            DATA: begin
                in_ready = adv && !rst;
                cur_bit  = in_bit;
                emit     = in_valid && in_ready;
                if (emit && in_last) state_nxt = TAIL;
            end
            TAIL: begin
                emit      = adv;
                last_pair = (tail_cnt == TAIL_LAST);
                if (adv && last_pair) state_nxt = DATA;
            end
            default: state_nxt = DATA;
        endcase
    end

    // Output register stage: a pair is held until the downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            tail_cnt  <= '0;
            out_pair  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (state == DATA)
                tail_cnt <= '0;
            else if (adv)
                tail_cnt <= tail_cnt + 1'b1;

            if (emit) begin
                out_pair  <= pair_nxt;
                out_valid <= 1'b1;
                out_last  <= last_pair;
                sr        <= window[K-1:1];
            end else if (adv) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef CONV_ENC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            pair_cnt  <= '0;
        end else if (out_valid && out_ready) begin
            pair_cnt <= pair_cnt + 1'b1;
            if (out_last) frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Bench for conv_encoder_k7: table vectors, random frames against a convolution
// model, backpressure, back-to-back frames and reset during the tail.
module tb_conv_encoder_k7;

    localparam logic [6:0] GA = 7'o171;
    localparam logic [6:0] GB = 7'o133;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic       out_last;
    logic [1:0] out_pair;
`ifdef CONV_ENC_STATS_EN
    logic [15:0] frame_cnt;
    logic [31:0] pair_cnt;
`endif

    conv_encoder_k7 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last)
`ifdef CONV_ENC_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .pair_cnt  (pair_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [1:0] exp_pair_q[$];
    logic       exp_last_q[$];
    bit         mon_en = 1'b0;
    bit         rnd_rdy = 1'b0;
    bit         prev_stall = 1'b0;
    logic [1:0] prev_pair = '0;
    logic       prev_last = 1'b0;

    typedef struct {
        int          len;
        logic [31:0] bits;
        int          npairs;
        logic [63:0] exp;
        bit          tail_chk;
    } vec_t;

    vec_t tbl[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout/extra event, expected none", name);
    endtask

    // Reference: each output pair is the mod-2 convolution of the frame
    // (zero-extended by 6 tail bits) with the generator taps.
    task automatic model_frame(input bit bits[$]);
        int n;
        n = bits.size();
        for (int t = 0; t < n + 6; t++) begin
            int s0 = 0;
            int s1 = 0;
            for (int j = 0; j < 7; j++) begin
                int idx = t - j;
                int b = (idx >= 0 && idx < n) ? int'(bits[idx]) : 0;
                s0 += b * int'(GA[6-j]);
                s1 += b * int'(GB[6-j]);
            end
            exp_pair_q.push_back({1'(s1 % 2), 1'(s0 % 2)});
            exp_last_q.push_back(t == n + 5);
        end
    endtask

    task automatic push_row(input int r);
        for (int i = 0; i < tbl[r].npairs; i++) begin
            exp_pair_q.push_back(tbl[r].exp[2*i +: 2]);
            exp_last_q.push_back(i == tbl[r].npairs - 1);
        end
    endtask

    task automatic send_bit(input bit b, input bit l);
        int w = 0;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 1000) begin
                fail_now("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input bit bits[$]);
        for (int i = 0; i < bits.size(); i++)
            send_bit(bits[i], i == bits.size() - 1);
    endtask

    task automatic rand_frame(input int len, output bit bits[$]);
        bits = {};
        for (int i = 0; i < len; i++) bits.push_back(bit'($urandom_range(1, 0)));
    endtask

    task automatic wait_drain(input string name);
        int w = 0;
        while (exp_pair_q.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_drain"}, 32'(exp_pair_q.size()), 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // Output monitor: checks every accepted pair and the hold-while-stalled rule.
    initial begin
        logic [1:0] ep;
        logic       el;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_pair", 32'(out_pair), 32'(prev_pair));
                    chk("hold_last", 32'(out_last), 32'(prev_last));
                end
                if (out_valid && out_ready) begin
                    if (exp_pair_q.size() == 0) begin
                        fail_now("unexpected_pair");
                    end else begin
                        ep = exp_pair_q.pop_front();
                        el = exp_last_q.pop_front();
                        chk("pair", 32'(out_pair), 32'(ep));
                        chk("last", 32'(out_last), 32'(el));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_pair  = out_pair;
                prev_last  = out_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fa[$];
        bit fb[$];

        // Expected pairs packed MSB-first as {out_pair[1], out_pair[0]}.
        tbl[0] = '{len: 1, bits: 32'h1, npairs: 7,
                   exp: 64'b11_10_00_11_11_01_11, tail_chk: 1'b0};
        tbl[1] = '{len: 2, bits: 32'h3, npairs: 8,
                   exp: 64'b11_01_10_11_00_10_10_11, tail_chk: 1'b0};
        tbl[2] = '{len: 20, bits: 32'h0, npairs: 26, exp: 64'h0, tail_chk: 1'b1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pair", 32'(out_pair), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef CONV_ENC_STATS_EN
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_pair_cnt", pair_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int r = 0; r < 3; r++) begin
            fa = {};
            for (int i = 0; i < tbl[r].len; i++) fa.push_back(tbl[r].bits[i]);
            push_row(r);
            send_frame(fa);
            if (tbl[r].tail_chk) begin
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    chk("tail_in_ready", 32'(in_ready), 32'd0);
                end
                @(negedge clk);
                chk("post_tail_in_ready", 32'(in_ready), 32'd1);
            end
            wait_drain("table");
        end

        rand_frame(3, fa);
        rand_frame(5, fb);
        model_frame(fa);
        model_frame(fb);
        send_frame(fa);
        send_frame(fb);
        wait_drain("b2b");

        rnd_rdy = 1'b1;
        rand_frame(100, fa);
        model_frame(fa);
        send_frame(fa);
        wait_drain("bp100");
        for (int f = 0; f < 4; f++) begin
            rand_frame(int'($urandom_range(12, 1)), fa);
            model_frame(fa);
            send_frame(fa);
        end
        wait_drain("bp_multi");
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Reset after the third tail pair has been emitted.
        rand_frame(4, fa);
        model_frame(fa);
        send_frame(fa);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("midtail_rst_valid", 32'(out_valid), 32'd0);
        chk("midtail_rst_last", 32'(out_last), 32'd0);
        chk("midtail_rst_in_ready", 32'(in_ready), 32'd0);
        exp_pair_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        fa = {1'b1};
        push_row(0);
        send_frame(fa);
        wait_drain("after_rst");

`ifdef CONV_ENC_STATS_EN
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            rand_frame(10, fa);
            model_frame(fa);
            send_frame(fa);
        end
        wait_drain("stats");
        chk("frame_cnt", 32'(frame_cnt), 32'd4);
        chk("pair_cnt", pair_cnt, 32'd64);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
